// File: rtl/id_ex_stage_if.sv
// Decode/execute/forwarding bus for id_ex_stage.
// master: the environment (decode, execute, MEM/WB forwarding sources).
// slave:  the ID/EX pipeline register.
interface id_ex_stage_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  flush;
  logic                  id_valid;
  logic                  id_ready;
  logic [DATA_WIDTH-1:0] id_pc;
  logic [DATA_WIDTH-1:0] id_rs1_data;
  logic [DATA_WIDTH-1:0] id_rs2_data;
  logic [DATA_WIDTH-1:0] id_imm;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic [3:0]            id_alu_controls;
  logic                  id_use_pc;
  logic                  id_use_imm;
  logic                  id_reg_write;
  logic                  ex_valid;
  logic                  ex_ready;
  logic [DATA_WIDTH-1:0] ex_a;
  logic [DATA_WIDTH-1:0] ex_b;
  logic [3:0]            ex_alu_controls;
  logic [DATA_WIDTH-1:0] ex_rs2_data;
  logic [DATA_WIDTH-1:0] ex_pc;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_reg_write;
  logic                  mem_fwd_valid;
  logic                  mem_fwd_is_load;
  logic [REG_ADDR_W-1:0] mem_fwd_rd;
  logic [DATA_WIDTH-1:0] mem_fwd_data;
  logic                  wb_fwd_valid;
  logic [REG_ADDR_W-1:0] wb_fwd_rd;
  logic [DATA_WIDTH-1:0] wb_fwd_data;

  modport master (
    output flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_controls,
           id_use_pc, id_use_imm, id_reg_write, ex_ready,
           mem_fwd_valid, mem_fwd_is_load, mem_fwd_rd, mem_fwd_data,
           wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
    input  id_ready, ex_valid, ex_a, ex_b, ex_alu_controls, ex_rs2_data,
           ex_pc, ex_rd_addr, ex_reg_write
  );

  modport slave (
    input  flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_controls,
           id_use_pc, id_use_imm, id_reg_write, ex_ready,
           mem_fwd_valid, mem_fwd_is_load, mem_fwd_rd, mem_fwd_data,
           wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
    output id_ready, ex_valid, ex_a, ex_b, ex_alu_controls, ex_rs2_data,
           ex_pc, ex_rd_addr, ex_reg_write
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32I core: single-entry holding stage with
// MEM/WB forwarding, WB snooping of held operands and load-use bubble insertion.
// Optional macro ID_EX_PERF_EN adds perf_load_stalls / perf_flushes counters.
module id_ex_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  id_ex_stage_if.slave   bus
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]    perf_load_stalls,
  output logic [31:0]    perf_flushes
`endif
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic [REG_ADDR_W-1:0] rs1a_q, rs1a_d, rs2a_q, rs2a_d, rd_q, rd_d;
  logic [3:0]            alu_q, alu_d;
  logic                  upc_q, upc_d, uimm_q, uimm_d, rw_q, rw_d;

  logic                  mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic                  wb_hit1_id, wb_hit2_id;
  logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;
  logic                  hazard, ex_valid_w, id_ready_w, accept, leave;

  // Forward matching on held sources, operand selection and handshake
  always_comb begin
    mem_hit1   = bus.mem_fwd_valid && (bus.mem_fwd_rd == rs1a_q) && (rs1a_q != '0);
    mem_hit2   = bus.mem_fwd_valid && (bus.mem_fwd_rd == rs2a_q) && (rs2a_q != '0);
    wb_hit1    = bus.wb_fwd_valid && (bus.wb_fwd_rd == rs1a_q) && (rs1a_q != '0);
    wb_hit2    = bus.wb_fwd_valid && (bus.wb_fwd_rd == rs2a_q) && (rs2a_q != '0);
    wb_hit1_id = bus.wb_fwd_valid && (bus.wb_fwd_rd == bus.id_rs1_addr) && (bus.id_rs1_addr != '0);
    wb_hit2_id = bus.wb_fwd_valid && (bus.wb_fwd_rd == bus.id_rs2_addr) && (bus.id_rs2_addr != '0);

    if (rs1a_q == '0)                         fwd_rs1 = '0;
    else if (mem_hit1 && !bus.mem_fwd_is_load) fwd_rs1 = bus.mem_fwd_data;
    else if (wb_hit1)                          fwd_rs1 = bus.wb_fwd_data;
    else                                       fwd_rs1 = rs1_q;

    if (rs2a_q == '0)                         fwd_rs2 = '0;
    else if (mem_hit2 && !bus.mem_fwd_is_load) fwd_rs2 = bus.mem_fwd_data;
    else if (wb_hit2)                          fwd_rs2 = bus.wb_fwd_data;
    else                                       fwd_rs2 = rs2_q;

    // rs2 counts as used for stores (reg_write=0) even with an immediate b
    hazard     = valid_q && bus.mem_fwd_is_load &&
                 ((mem_hit1 && !upc_q) || (mem_hit2 && (!uimm_q || !rw_q)));
    ex_valid_w = valid_q && !hazard;
    id_ready_w = !valid_q || (ex_valid_w && bus.ex_ready);
    accept     = bus.id_valid && id_ready_w && !bus.flush;
    leave      = ex_valid_w && bus.ex_ready;
  end

  assign bus.ex_valid        = ex_valid_w;
  assign bus.id_ready        = id_ready_w;
  assign bus.ex_a            = upc_q ? pc_q : fwd_rs1;
  assign bus.ex_b            = uimm_q ? imm_q : fwd_rs2;
  assign bus.ex_rs2_data     = fwd_rs2;
  assign bus.ex_alu_controls = alu_q;
  assign bus.ex_pc           = pc_q;
  assign bus.ex_rd_addr      = rd_q;
  assign bus.ex_reg_write    = rw_q;

  // Next-state: flush > capture (with WB snoop of regfile data) > leave / hold-snoop
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    rs1a_d  = rs1a_q;
    rs2a_d  = rs2a_q;
    rd_d    = rd_q;
    alu_d   = alu_q;
    upc_d   = upc_q;
    uimm_d  = uimm_q;
    rw_d    = rw_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      pc_d    = bus.id_pc;
      rs1_d   = wb_hit1_id ? bus.wb_fwd_data : bus.id_rs1_data;
      rs2_d   = wb_hit2_id ? bus.wb_fwd_data : bus.id_rs2_data;
      imm_d   = bus.id_imm;
      rs1a_d  = bus.id_rs1_addr;
      rs2a_d  = bus.id_rs2_addr;
      rd_d    = bus.id_rd_addr;
      alu_d   = bus.id_alu_controls;
      upc_d   = bus.id_use_pc;
      uimm_d  = bus.id_use_imm;
      rw_d    = bus.id_reg_write;
    end else begin
      if (leave) valid_d = 1'b0;
      if (wb_hit1) rs1_d = bus.wb_fwd_data;
      if (wb_hit2) rs2_d = bus.wb_fwd_data;
    end
  end

  // Held entry registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      rs1a_q  <= '0;
      rs2a_q  <= '0;
      rd_q    <= '0;
      alu_q   <= 4'b0000;
      upc_q   <= 1'b0;
      uimm_q  <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      rs1a_q  <= rs1a_d;
      rs2a_q  <= rs2a_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      upc_q   <= upc_d;
      uimm_q  <= uimm_d;
      rw_q    <= rw_d;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] stalls_q, flushes_q;

  // Load-use stall cycles and flushes that kill a held entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      if (hazard)                 stalls_q  <= stalls_q + 32'd1;
      if (bus.flush && valid_q)   flushes_q <= flushes_q + 32'd1;
    end
  end

  assign perf_load_stalls = stalls_q;
  assign perf_flushes     = flushes_q;
`endif

endmodule
